// File: rtl/circuit_feeder.sv
// circuit_feeder: FIFO-buffered frame streamer that drives circuit's en/x sample pair.
// Optional feature: define CIRCUIT_FEEDER_ZERO_PAD_EN to issue zero samples instead of stalling on an empty FIFO.
module circuit_feeder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FIFO_ADDR_W = 4,
    parameter int unsigned FRAME_LEN   = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 full,
    output logic [FIFO_ADDR_W:0] level,
    output logic                 ovf,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 en,
    output logic [DATA_W-1:0]    x
);
    localparam int unsigned DEPTH = 2 ** FIFO_ADDR_W;
    localparam int unsigned LVL_W = FIFO_ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       cnt;
    logic [LVL_W-1:0]       level_nxt;
    logic                   empty, push, pop, issue;

    // full is the registered flag, so a push against a full FIFO is dropped even if a pop happens
    assign empty = (level == '0);
    assign push  = wr_en && !full;

    // Next-state and issue decision
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                pop = !empty;
`ifdef CIRCUIT_FEEDER_ZERO_PAD_EN
                issue = 1'b1;
`else
                issue = !empty;
`endif
                if (issue && (cnt == CNT_W'(FRAME_LEN - 1))) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (!push && pop) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers and level
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            en     <= 1'b0;
            x      <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                cnt <= '0;
            end else if (issue) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(DEPTH));
            if (wr_en && full) ovf <= 1'b1;
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            en   <= issue;
            // x holds its last value while stalled
            if (issue) x <= pop ? mem[rd_ptr] : '0;
        end
    end
endmodule

// File: tb/tb_circuit_feeder.sv
// Testbench for circuit_feeder: directed vector table, frame sequences and random traffic against a queue model.
module tb_circuit_feeder;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned FIFO_ADDR_W = 4;
    localparam int unsigned FRAME_LEN   = 100;
    localparam int          DEPTH       = 16;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic [4:0]        level;
    logic              ovf;
    logic              start;
    logic              busy;
    logic              done;
    logic              en;
    logic [DATA_W-1:0] x;

    circuit_feeder #(
        .DATA_W      (DATA_W),
        .FIFO_ADDR_W (FIFO_ADDR_W),
        .FRAME_LEN   (FRAME_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .level   (level),
        .ovf     (ovf),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .en      (en),
        .x       (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a sample queue plus frame bookkeeping
    logic [31:0] mq[$];
    bit          m_active, m_finishing, m_ovf, m_en, m_done;
    int          m_issued;
    logic [31:0] m_x;

    // Observed traffic for the sequence-level checks
    int          n_en, n_done;
    logic [31:0] x_at_done;
    bit          en_at_done;
    logic [31:0] got[$];

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] d;
        bit          s;
        logic [4:0]  lvl;
        bit          bsy;
        bit          e;
        logic [31:0] xv;
        bit          dn;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit w, input logic [31:0] d, input bit s);
        int had;
        if (r) begin
            mq.delete();
            m_active = 0; m_finishing = 0; m_ovf = 0; m_en = 0; m_done = 0;
            m_issued = 0; m_x = '0;
            return;
        end
        had    = mq.size();
        m_en   = 0;
        m_done = 0;
        if (m_finishing) begin
            m_finishing = 0;
        end else if (m_active) begin
            if (had > 0) begin
                m_x = mq.pop_front();
                m_en = 1;
                m_issued++;
            end
`ifdef CIRCUIT_FEEDER_ZERO_PAD_EN
            else begin
                m_x = '0;
                m_en = 1;
                m_issued++;
            end
`endif
            if (m_issued == int'(FRAME_LEN)) begin
                m_active = 0; m_finishing = 1; m_done = 1;
            end
        end else if (s) begin
            m_active = 1;
            m_issued = 0;
        end
        if (w) begin
            if (had == DEPTH) m_ovf = 1;
            else mq.push_back(d);
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [31:0] d, input bit s);
        rst = r; wr_en = w; wr_data = d; start = s;
        @(posedge clk);
        model_update(r, w, d, s);
        #1;
        chk("en",    64'(en),    64'(m_en));
        chk("x",     64'(x),     64'(m_x));
        chk("busy",  64'(busy),  64'(m_active || m_finishing));
        chk("done",  64'(done),  64'(m_done));
        chk("level", 64'(level), 64'(mq.size()));
        chk("full",  64'(full),  64'(mq.size() == DEPTH));
        chk("ovf",   64'(ovf),   64'(m_ovf));
        if (en) begin
            n_en++;
            got.push_back(x);
        end
        if (done) begin
            n_done++;
            x_at_done  = x;
            en_at_done = en;
        end
    endtask

    task automatic clear_obs();
        n_en = 0; n_done = 0; x_at_done = '0; en_at_done = 0;
        got.delete();
    endtask

    task automatic run_idle(input int max_cycles);
        int k;
        k = 0;
        while (busy && k < max_cycles) begin
            step(0, 0, 32'h0, 0);
            k++;
        end
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
        clear_obs();

        // r, w, d, s | level, busy, en, x, done
        tbl[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0, 1'b0, 32'h0,  1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'hA1, 1'b0, 5'd1, 1'b0, 1'b0, 32'h0,  1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'hA2, 1'b0, 5'd2, 1'b0, 1'b0, 32'h0,  1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 5'd2, 1'b1, 1'b0, 32'h0,  1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd1, 1'b1, 1'b1, 32'hA1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b1, 32'hA2, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0, 32'hA2, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'hA3, 1'b1, 5'd1, 1'b1, 1'b0, 32'hA2, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b1, 32'hA3, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0, 1'b0, 32'h0,  1'b0};
`ifdef CIRCUIT_FEEDER_ZERO_PAD_EN
        tbl[6].e = 1'b1; tbl[6].xv = 32'h0;
        tbl[7].e = 1'b1; tbl[7].xv = 32'h0;
`endif

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].s);
            chk("tbl_level", 64'(level), 64'(tbl[i].lvl));
            chk("tbl_busy",  64'(busy),  64'(tbl[i].bsy));
            chk("tbl_en",    64'(en),    64'(tbl[i].e));
            chk("tbl_x",     64'(x),     64'(tbl[i].xv));
            chk("tbl_done",  64'(done),  64'(tbl[i].dn));
        end

        // Start with an empty FIFO, then feed a whole frame
        step(1, 0, 32'h0, 0);
        clear_obs();
        step(0, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0);
        chk("empty_start_busy", 64'(busy), 64'(1));
        for (int v = 1; v <= 100; v++) step(0, 1, 32'(v + 1000), 0);
        run_idle(50);
        chk("empty_start_nen",   64'(n_en),   64'(100));
        chk("empty_start_ndone", 64'(n_done), 64'(1));

        // Overflow on the 17th push, then an ordered 1..100 frame with live pushes
        step(1, 0, 32'h0, 0);
        for (int v = 1; v <= 16; v++) step(0, 1, 32'(v), 0);
        step(0, 1, 32'd999, 0);
        chk("ovf_full",  64'(full),  64'(1));
        chk("ovf_level", 64'(level), 64'(16));
        chk("ovf_flag",  64'(ovf),   64'(1));
        clear_obs();
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 0);
        for (int v = 17; v <= 100; v++) step(0, 1, 32'(v), 0);
        run_idle(40);
        chk("order_nen",   64'(n_en),   64'(100));
        chk("order_ndone", 64'(n_done), 64'(1));
        chk("order_last_x",  64'(x_at_done),  64'(100));
        chk("order_last_en", 64'(en_at_done), 64'(1));
        for (int i = 0; i < got.size() && i < 100; i++) chk("order_x", 64'(got[i]), 64'(i + 1));

        // Stall with three samples, then complete the frame
        step(1, 0, 32'h0, 0);
        clear_obs();
        for (int v = 201; v <= 203; v++) step(0, 1, 32'(v), 0);
        step(0, 0, 32'h0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 0);
`ifndef CIRCUIT_FEEDER_ZERO_PAD_EN
        chk("stall_x",    64'(x),    64'(203));
        chk("stall_busy", 64'(busy), 64'(1));
        chk("stall_nen",  64'(n_en), 64'(3));
`endif
        for (int v = 204; v <= 300; v++) step(0, 1, 32'(v), 0);
        run_idle(50);
        chk("stall_total_nen", 64'(n_en),   64'(100));
        chk("stall_ndone",     64'(n_done), 64'(1));

        // Reset mid-frame after 40 issues, then a clean frame
        step(1, 0, 32'h0, 0);
        clear_obs();
        for (int v = 0; v < 16; v++) step(0, 1, 32'(300 + v), 0);
        step(0, 0, 32'h0, 1);
        for (int k = 0; k < 200 && n_en < 40; k++) step(0, 1, 32'(400 + k), 0);
        chk("pre_rst_nen", 64'(n_en), 64'(40));
        step(1, 0, 32'h0, 0);
        chk("rst_busy",  64'(busy),  64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_en",    64'(en),    64'(0));
        chk("rst_x",     64'(x),     64'(0));
        clear_obs();
        step(0, 0, 32'h0, 1);
        for (int v = 0; v < 100; v++) step(0, 1, 32'(500 + v), (v % 7) == 3);
        run_idle(200);
        chk("post_rst_nen",   64'(n_en),   64'(100));
        chk("post_rst_ndone", 64'(n_done), 64'(1));

        // Random traffic with occasional starts and resets
        step(1, 0, 32'h0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 60,
                 32'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
